// File: rtl/lif_spike_rate_decoder.sv
// Spike-rate decoder: counts rising edges of the neuron spike line over a
// programmable window, publishes a saturating count with a valid strobe and
// drives a 7-segment digit with the clamped rate.
module lif_spike_rate_decoder #(
   parameter int unsigned WINDOW_W = 16,
   parameter int unsigned COUNT_W  = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [WINDOW_W-1:0] window_len,
   input  logic                spike_in,
   output logic [COUNT_W-1:0]  rate_out,
   output logic                rate_valid,
   output logic                ovf,
   output logic                busy,
   output logic [6:0]          segments
);

   localparam logic [COUNT_W-1:0] CNT_MAX  = '1;
   localparam logic [6:0]         SEG_ZERO = 7'h3F;

   typedef enum logic {
      IDLE,
      COUNT
   } state_t;

   state_t              state;
   state_t              next_state;
   logic                spike_q;
   logic                spike_edge;
   logic                can_start;
   logic                win_close;
   logic                at_max;
   logic [COUNT_W-1:0]  count;
   logic [COUNT_W-1:0]  count_inc;
   logic                ovf_acc;
   logic                ovf_inc;
   logic [WINDOW_W-1:0] win_cnt;

   assign spike_edge = spike_in & ~spike_q;
   assign can_start  = en && (window_len != '0);
   assign win_close  = (win_cnt == '0);
   assign at_max     = (count == CNT_MAX);
   // Count and overflow as they stand including this cycle's edge.
   assign count_inc  = (spike_edge && !at_max) ? count + COUNT_W'(1) : count;
   assign ovf_inc    = ovf_acc | (spike_edge & at_max);

   // Hex glyph of the rate, clamped to F for anything above 15.
   function automatic logic [6:0] glyph(input logic [COUNT_W-1:0] v);
      logic [3:0] d;
      d = (v > COUNT_W'(15)) ? 4'hF : v[3:0];
      case (d)
         4'h0: glyph = 7'h3F;
         4'h1: glyph = 7'h06;
         4'h2: glyph = 7'h5B;
         4'h3: glyph = 7'h4F;
         4'h4: glyph = 7'h66;
         4'h5: glyph = 7'h6D;
         4'h6: glyph = 7'h7D;
         4'h7: glyph = 7'h07;
         4'h8: glyph = 7'h7F;
         4'h9: glyph = 7'h6F;
         4'hA: glyph = 7'h77;
         4'hB: glyph = 7'h7C;
         4'hC: glyph = 7'h39;
         4'hD: glyph = 7'h5E;
         4'hE: glyph = 7'h79;
         default: glyph = 7'h71;
      endcase
   endfunction

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Next-state: start when enabled with a nonzero window, leave on disable
   // or when a window closes with no valid reload.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (can_start) next_state = COUNT;
         COUNT: begin
            if (!en)                         next_state = IDLE;
            else if (win_close && !can_start) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Edge history, window counting and published outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         spike_q    <= 1'b0;
         count      <= '0;
         ovf_acc    <= 1'b0;
         win_cnt    <= '0;
         rate_out   <= '0;
         rate_valid <= 1'b0;
         ovf        <= 1'b0;
         busy       <= 1'b0;
         segments   <= SEG_ZERO;
      end else begin
         spike_q    <= spike_in;
         rate_valid <= 1'b0;
         busy       <= (next_state == COUNT);
         case (state)
            IDLE: begin
               // Edges in the entry cycle are deliberately not counted.
               if (can_start) begin
                  win_cnt <= window_len - WINDOW_W'(1);
                  count   <= '0;
                  ovf_acc <= 1'b0;
               end
            end
            COUNT: begin
               if (en) begin
                  if (win_close) begin
                     rate_out   <= count_inc;
                     ovf        <= ovf_inc;
                     rate_valid <= 1'b1;
                     segments   <= glyph(count_inc);
                     // Back-to-back reload with no gap cycle.
                     if (can_start) begin
                        win_cnt <= window_len - WINDOW_W'(1);
                        count   <= '0;
                        ovf_acc <= 1'b0;
                     end
                  end else begin
                     win_cnt <= win_cnt - WINDOW_W'(1);
                     count   <= count_inc;
                     ovf_acc <= ovf_inc;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lif_spike_rate_decoder.sv
// Directed bench for lif_spike_rate_decoder.
module tb_lif_spike_rate_decoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [15:0] window_len;
   logic        spike_in;
   logic [7:0]  rate_out;
   logic        rate_valid;
   logic        ovf;
   logic        busy;
   logic [6:0]  segments;

   int tests = 0;
   int fails = 0;

   lif_spike_rate_decoder #(.WINDOW_W(16), .COUNT_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .window_len (window_len),
      .spike_in   (spike_in),
      .rate_out   (rate_out),
      .rate_valid (rate_valid),
      .ovf        (ovf),
      .busy       (busy),
      .segments   (segments)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; en = 1'b0; spike_in = 1'b0;
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; window_len = 16'd10; spike_in = 1'b0;
      for (int i = 0; i < 4; i++) begin
         spike_in = ~spike_in;
         tick();
      end
      tests++; if (rate_out !== 8'd0)   begin fails++; $display("FAIL reset_rate_out got %0h want 0", rate_out); end
      tests++; if (rate_valid !== 1'b0) begin fails++; $display("FAIL reset_rate_valid got %b want 0", rate_valid); end
      tests++; if (ovf !== 1'b0)        begin fails++; $display("FAIL reset_ovf got %b want 0", ovf); end
      tests++; if (busy !== 1'b0)       begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
      tests++; if (segments !== 7'h3F)  begin fails++; $display("FAIL reset_segments got %h want 3f", segments); end
      rst = 1'b0; en = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_en0_busy got %b want 0", busy); end
      en = 1'b1; window_len = 16'd0;
      for (int i = 0; i < 3; i++) tick();
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_len0_busy got %b want 0", busy); end
      en = 1'b0; spike_in = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      int pulses = 0;
      int pulse_at = -1;
      do_reset();
      en = 1'b1; window_len = 16'd10; spike_in = 1'b0;
      tick();
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_entry_busy got %b want 1", busy); end
      for (int i = 1; i <= 10; i++) begin
         spike_in = (i == 2 || i == 5 || i == 8);
         tick();
         if (rate_valid) begin pulses++; pulse_at = i; end
      end
      tests++; if (pulses !== 1)     begin fails++; $display("FAIL basic_pulses got %0d want 1", pulses); end
      tests++; if (pulse_at !== 10)  begin fails++; $display("FAIL basic_pulse_at got %0d want 10", pulse_at); end
      tests++; if (rate_out !== 8'd3) begin fails++; $display("FAIL basic_rate got %0d want 3", rate_out); end
      tests++; if (ovf !== 1'b0)     begin fails++; $display("FAIL basic_ovf got %b want 0", ovf); end
      tests++; if (segments !== 7'h4F) begin fails++; $display("FAIL basic_segments got %h want 4f", segments); end
      tests++; if (busy !== 1'b1)    begin fails++; $display("FAIL basic_busy got %b want 1", busy); end
      spike_in = 1'b0;
      tick();
      tests++; if (rate_valid !== 1'b0) begin fails++; $display("FAIL basic_pulse_width got %b want 0", rate_valid); end
   endtask

   task automatic test_held();
      do_reset();
      en = 1'b1; window_len = 16'd10; spike_in = 1'b0;
      tick();
      for (int i = 1; i <= 10; i++) begin
         spike_in = ((i >= 2 && i <= 6) || i == 8);
         tick();
      end
      tests++; if (rate_valid !== 1'b1) begin fails++; $display("FAIL held_valid got %b want 1", rate_valid); end
      tests++; if (rate_out !== 8'd2)   begin fails++; $display("FAIL held_rate got %0d want 2", rate_out); end
      tests++; if (segments !== 7'h5B)  begin fails++; $display("FAIL held_segments got %h want 5b", segments); end
   endtask

   task automatic test_saturate();
      int pulses = 0;
      do_reset();
      en = 1'b1; window_len = 16'd600; spike_in = 1'b0;
      tick();
      for (int i = 1; i <= 600; i++) begin
         spike_in = (i % 2 == 1);
         tick();
         if (rate_valid) pulses++;
      end
      tests++; if (pulses !== 1)         begin fails++; $display("FAIL sat_pulses got %0d want 1", pulses); end
      tests++; if (rate_out !== 8'd255)  begin fails++; $display("FAIL sat_rate got %0d want 255", rate_out); end
      tests++; if (ovf !== 1'b1)         begin fails++; $display("FAIL sat_ovf got %b want 1", ovf); end
      tests++; if (segments !== 7'h71)   begin fails++; $display("FAIL sat_segments got %h want 71", segments); end
      spike_in = 1'b0;
      for (int i = 1; i <= 600; i++) tick();
      tests++; if (rate_valid !== 1'b1) begin fails++; $display("FAIL quiet_valid got %b want 1", rate_valid); end
      tests++; if (rate_out !== 8'd0)   begin fails++; $display("FAIL quiet_rate got %0d want 0", rate_out); end
      tests++; if (ovf !== 1'b0)        begin fails++; $display("FAIL quiet_ovf got %b want 0", ovf); end
      tests++; if (segments !== 7'h3F)  begin fails++; $display("FAIL quiet_segments got %h want 3f", segments); end
   endtask

   task automatic test_back_to_back();
      logic [3:0] pat;
      pat = 4'b1010;
      do_reset();
      en = 1'b1; window_len = 16'd1; spike_in = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         spike_in = pat[i];
         tick();
         tests++; if (rate_valid !== 1'b1) begin fails++; $display("FAIL len1_valid[%0d] got %b want 1", i, rate_valid); end
         tests++; if (rate_out !== {7'd0, pat[i]}) begin fails++; $display("FAIL len1_rate[%0d] got %0d want %0d", i, rate_out, pat[i]); end
      end
   endtask

   task automatic test_abort();
      int pulses = 0;
      do_reset();
      en = 1'b1; window_len = 16'd10; spike_in = 1'b0;
      tick();
      for (int i = 1; i <= 10; i++) begin
         spike_in = (i == 3);
         tick();
      end
      tests++; if (rate_out !== 8'd1) begin fails++; $display("FAIL abort_prev_rate got %0d want 1", rate_out); end
      for (int i = 1; i <= 4; i++) begin
         spike_in = (i == 1 || i == 3);
         tick();
      end
      en = 1'b0; spike_in = 1'b0;
      tick();
      tests++; if (busy !== 1'b0)       begin fails++; $display("FAIL abort_busy got %b want 0", busy); end
      tests++; if (rate_valid !== 1'b0) begin fails++; $display("FAIL abort_valid got %b want 0", rate_valid); end
      tests++; if (rate_out !== 8'd1)   begin fails++; $display("FAIL abort_rate_hold got %0d want 1", rate_out); end
      tests++; if (segments !== 7'h06)  begin fails++; $display("FAIL abort_seg_hold got %h want 06", segments); end
      for (int i = 0; i < 12; i++) begin
         tick();
         if (rate_valid) pulses++;
      end
      tests++; if (pulses !== 0) begin fails++; $display("FAIL abort_late_pulses got %0d want 0", pulses); end
      en = 1'b1;
      tick();
      for (int i = 1; i <= 4; i++) begin
         spike_in = (i == 1 || i == 3);
         tick();
      end
      rst = 1'b1;
      #1;
      tests++; if (rate_out !== 8'd0)  begin fails++; $display("FAIL rst_mid_rate got %0d want 0", rate_out); end
      tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL rst_mid_busy got %b want 0", busy); end
      tests++; if (segments !== 7'h3F) begin fails++; $display("FAIL rst_mid_segments got %h want 3f", segments); end
      tests++; if (ovf !== 1'b0)       begin fails++; $display("FAIL rst_mid_ovf got %b want 0", ovf); end
      tests++; if (rate_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_valid got %b want 0", rate_valid); end
      rst = 1'b0; en = 1'b0; spike_in = 1'b0;
      tick();
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; window_len = '0; spike_in = 1'b0;
      test_reset();
      test_basic();
      test_held();
      test_saturate();
      test_back_to_back();
      test_abort();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
